irq_ctrl: RTL and testbench

Parametrised interrupt controller for the 6502 board. It collects up to NCH external interrupt sources and one NMI source, and synchronises and edge/level-qualifies them. It drives the core's single `irq` and `nmi` lines, with an acknowledge/end-of-interrupt handshake. A small register window lets firmware mask sources and read the active channel.

---
 rtl/irq_ctrl_if.sv | 26 ++
 rtl/irq_ctrl.sv | 156 +++++++++++++++
 tb/tb_irq_ctrl.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/irq_ctrl_if.sv
// Bus bundle between the 6502 core/firmware side and the interrupt controller.
interface irq_ctrl_if #(
   parameter int NCH = 8
);
   logic [NCH-1:0] src;
   logic           nmi_src;
   logic           irq;
   logic           nmi;
   logic           irqack;
   logic           nmiack;
   logic [1:0]     addr;
   logic           wr;
   logic           rd;
   logic [7:0]     wdata;
   logic [7:0]     rdata;

   modport master (
      output src, nmi_src, irqack, nmiack, addr, wr, rd, wdata,
      input  irq, nmi, rdata
   );

   modport slave (
      input  src, nmi_src, irqack, nmiack, addr, wr, rd, wdata,
      output irq, nmi, rdata
   );
endinterface

// File: rtl/irq_ctrl.sv
// Interrupt controller for the 6502 board: synchronised IRQ channels with
// per-channel edge/level mode, lowest-index priority, ack/EOI handshake,
// and a falling-edge NMI path that bypasses masking.
//
// state     | meaning
// ----------+---------------------------------------------------
// S_IDLE    | no request outstanding, irq low
// S_REQ     | enabled source pending, irq high, waiting for irqack
// S_SERVICE | core is in the handler, irq low until EOI write
module irq_ctrl #(
   parameter int         NCH  = 8,
   parameter logic [7:0] EDGE = 8'hFF
) (
   input logic     clk,
   input logic     clr,
   irq_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_REQ     = 2'd1,
      S_SERVICE = 2'd2
   } state_t;

   localparam logic [NCH-1:0] EDGE_M = EDGE[NCH-1:0];

   state_t         state_q, state_d;
   logic [NCH-1:0] src_s1_q, src_s1_d;
   logic [NCH-1:0] src_s2_q, src_s2_d;
   logic [NCH-1:0] src_s3_q, src_s3_d;
   logic [2:0]     nmi_s_q, nmi_s_d;
   logic [NCH-1:0] pend_q, pend_d;
   logic [NCH-1:0] mask_q, mask_d;
   logic           gen_q, gen_d;
   logic           nmipend_q, nmipend_d;
   logic [2:0]     cur_q, cur_d;
   logic [7:0]     rdata_q, rdata_d;

   logic [NCH-1:0] rise;
   logic [NCH-1:0] pm;
   logic [NCH-1:0] clr_bits;
   logic           req;
   logic [2:0]     id;
   logic [7:0]     pend8, mask8, rd_val;
   logic           wr_pend, wr_mask, wr_ctrl, eoi, nmi_fall, ack_take;

   // synchroniser chains; third stage only feeds edge detection
   always_comb begin
      src_s1_d = bus.src;
      src_s2_d = src_s1_q;
      src_s3_d = src_s2_q;
      nmi_s_d  = {nmi_s_q[1:0], bus.nmi_src};
   end

   // edge qualification, request and lowest-index priority
   always_comb begin
      rise     = src_s2_q & ~src_s3_q;
      nmi_fall = ~nmi_s_q[1] & nmi_s_q[2];
      pm       = pend_q & mask_q;
      req      = gen_q & (|pm);
      id       = '0;
      for (int i = NCH - 1; i >= 0; i--) begin
         if (pm[i]) id = 3'(i);
      end
      pend8 = '0;
      pend8[NCH-1:0] = pend_q;
      mask8 = '0;
      mask8[NCH-1:0] = mask_q;
      wr_pend  = bus.wr && (bus.addr == 2'd0);
      wr_mask  = bus.wr && (bus.addr == 2'd1);
      wr_ctrl  = bus.wr && (bus.addr == 2'd3);
      eoi      = wr_ctrl && bus.wdata[1];
      ack_take = (state_q == S_REQ) && bus.irqack;
   end

   // IRQ handshake state machine
   always_comb begin
      state_d = state_q;
      cur_d   = cur_q;
      case (state_q)
         S_IDLE: begin
            if (req) state_d = S_REQ;
         end
         S_REQ: begin
            if (bus.irqack) begin
               state_d = S_SERVICE;
               cur_d   = id;
            end else if (!req) begin
               state_d = S_IDLE;
            end
         end
         S_SERVICE: begin
            if (eoi) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // pending/mask/control registers; a new edge outranks any clear
   always_comb begin
      clr_bits = '0;
      if (wr_pend) clr_bits = bus.wdata[NCH-1:0];
      for (int i = 0; i < NCH; i++) begin
         if (ack_take && (id == 3'(i))) clr_bits[i] = 1'b1;
      end
      pend_d    = ((rise | (pend_q & ~clr_bits)) & EDGE_M) | (src_s2_q & ~EDGE_M);
      mask_d    = wr_mask ? bus.wdata[NCH-1:0] : mask_q;
      gen_d     = wr_ctrl ? bus.wdata[0] : gen_q;
      nmipend_d = nmi_fall | (nmipend_q & ~bus.nmiack);
   end

   // read mux samples pre-write values, so rd+wr returns the old contents
   always_comb begin
      case (bus.addr)
         2'd0:    rd_val = pend8;
         2'd1:    rd_val = mask8;
         2'd2:    rd_val = {req, 4'b0000, id};
         default: rd_val = {5'b00000, state_q, gen_q};
      endcase
      rdata_d = bus.rd ? rd_val : rdata_q;
   end

   // all state flops
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state_q   <= S_IDLE;
         src_s1_q  <= '0;
         src_s2_q  <= '0;
         src_s3_q  <= '0;
         nmi_s_q   <= '0;
         pend_q    <= '0;
         mask_q    <= '0;
         gen_q     <= 1'b0;
         nmipend_q <= 1'b0;
         cur_q     <= '0;
         rdata_q   <= '0;
      end else begin
         state_q   <= state_d;
         src_s1_q  <= src_s1_d;
         src_s2_q  <= src_s2_d;
         src_s3_q  <= src_s3_d;
         nmi_s_q   <= nmi_s_d;
         pend_q    <= pend_d;
         mask_q    <= mask_d;
         gen_q     <= gen_d;
         nmipend_q <= nmipend_d;
         cur_q     <= cur_d;
         rdata_q   <= rdata_d;
      end
   end

   assign bus.irq   = (state_q == S_REQ);
   assign bus.nmi   = nmipend_q;
   assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: directed scenarios plus randomized traffic, all
// compared each cycle against a sample-history reference model.
module tb_irq_ctrl;

   localparam logic [7:0] EDGE_P = 8'hFE;

   logic clk;
   logic clr;
   int   n_chk  = 0;
   int   n_fail = 0;

   irq_ctrl_if #(.NCH(8)) ifc ();

   irq_ctrl #(.NCH(8), .EDGE(EDGE_P)) dut (
      .clk (clk),
      .clr (clr),
      .bus (ifc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // reference model state
   logic [7:0] m_pend, m_mask, m_rdata;
   logic       m_gen, m_nmipend;
   int         m_st;           // 0 idle, 1 requesting, 2 in service
   logic [7:0] hist[$];        // src samples taken at past edges, newest first
   logic       nh[$];          // nmi_src samples, newest first

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int lowest(input logic [7:0] v);
      for (int i = 0; i < 8; i++) if (v[i]) return i;
      return 0;
   endfunction

   task automatic model_reset();
      m_pend = '0; m_mask = '0; m_rdata = '0;
      m_gen = 1'b0; m_nmipend = 1'b0; m_st = 0;
      hist = '{8'h00, 8'h00, 8'h00};
      nh   = '{1'b0, 1'b0, 1'b0};
   endtask

   task automatic model_step();
      logic [7:0] pm, rose, clrm;
      logic       req_o, fell, eoi;
      int         id_o;
      pm    = m_pend & m_mask;
      req_o = m_gen && (pm != 8'h00);
      id_o  = lowest(pm);
      if (ifc.rd) begin
         case (ifc.addr)
            2'd0: m_rdata = m_pend;
            2'd1: m_rdata = m_mask;
            2'd2: m_rdata = {req_o, 4'b0000, 3'(id_o)};
            default: m_rdata = {5'b00000, 2'(m_st), m_gen};
         endcase
      end
      // a source change is seen as an edge two samples later
      rose = hist[1] & ~hist[2];
      clrm = (ifc.wr && ifc.addr == 2'd0) ? ifc.wdata : 8'h00;
      if (m_st == 1 && ifc.irqack) clrm[id_o] = 1'b1;
      for (int i = 0; i < 8; i++) begin
         if (EDGE_P[i]) m_pend[i] = rose[i] | (m_pend[i] & ~clrm[i]);
         else           m_pend[i] = hist[1][i];
      end
      if (ifc.wr && ifc.addr == 2'd1) m_mask = ifc.wdata;
      if (ifc.wr && ifc.addr == 2'd3) m_gen = ifc.wdata[0];
      eoi = ifc.wr && ifc.addr == 2'd3 && ifc.wdata[1];
      case (m_st)
         0: if (req_o) m_st = 1;
         1: if (ifc.irqack) m_st = 2; else if (!req_o) m_st = 0;
         default: if (eoi) m_st = 0;
      endcase
      fell = !nh[1] && nh[2];
      m_nmipend = fell | (m_nmipend & ~ifc.nmiack);
      hist.push_front(ifc.src);
      void'(hist.pop_back());
      nh.push_front(ifc.nmi_src);
      void'(nh.pop_back());
   endtask

   // one clock: model follows the edge, outputs compared 1 ns later,
   // then single-cycle strobes drop
   task automatic cyc();
      @(posedge clk);
      model_step();
      #1;
      chk("irq", 32'(ifc.irq), 32'(m_st == 1));
      chk("nmi", 32'(ifc.nmi), 32'(m_nmipend));
      chk("rdata", 32'(ifc.rdata), 32'(m_rdata));
      ifc.wr = 1'b0; ifc.rd = 1'b0; ifc.irqack = 1'b0; ifc.nmiack = 1'b0;
   endtask

   task automatic wr_reg(input logic [1:0] a, input logic [7:0] d);
      ifc.wr = 1'b1; ifc.addr = a; ifc.wdata = d;
      cyc();
   endtask

   task automatic rd_reg(input logic [1:0] a, input string tag, input logic [7:0] exp);
      ifc.rd = 1'b1; ifc.addr = a;
      cyc();
      chk(tag, 32'(ifc.rdata), 32'(exp));
   endtask

   task automatic do_reset();
      #2;
      clr = 1'b0;
      #1;
      chk("rst_irq", 32'(ifc.irq), 32'd0);
      chk("rst_nmi", 32'(ifc.nmi), 32'd0);
      chk("rst_rdata", 32'(ifc.rdata), 32'd0);
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #2;
      clr = 1'b1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, n_fail %0d", n_fail);
      $fatal(1);
   end

   initial begin
      clr = 1'b0;
      ifc.src = '0; ifc.nmi_src = 1'b0; ifc.irqack = 1'b0; ifc.nmiack = 1'b0;
      ifc.addr = '0; ifc.wr = 1'b0; ifc.rd = 1'b0; ifc.wdata = '0;
      model_reset();
      #12 clr = 1'b1;

      // reset priority: reset while requesting with pend = 05
      wr_reg(2'd1, 8'hFF);
      wr_reg(2'd3, 8'h01);
      ifc.src = 8'h05;
      idle(4);
      chk("pre_rst_irq", 32'(ifc.irq), 32'd1);
      rd_reg(2'd0, "pre_rst_pend", 8'h05);
      ifc.src = 8'h00;
      do_reset();
      rd_reg(2'd0, "rst_pend", 8'h00);
      rd_reg(2'd1, "rst_mask", 8'h00);
      rd_reg(2'd3, "rst_ctrl", 8'h00);

      // two sources rising together, priority, ack and EOI
      wr_reg(2'd1, 8'hFF);
      wr_reg(2'd3, 8'h01);
      ifc.src = 8'h24;
      idle(3);
      chk("two_src_irq_early", 32'(ifc.irq), 32'd0);
      cyc();
      chk("two_src_irq", 32'(ifc.irq), 32'd1);
      rd_reg(2'd2, "two_src_id", 8'h82);
      ifc.irqack = 1'b1;
      cyc();
      chk("ack_irq_low", 32'(ifc.irq), 32'd0);
      rd_reg(2'd0, "ack_pend", 8'h20);
      rd_reg(2'd3, "service_ctrl", 8'h05);
      wr_reg(2'd3, 8'h03);
      cyc();
      chk("eoi_irq_again", 32'(ifc.irq), 32'd1);
      rd_reg(2'd2, "second_id", 8'h85);
      ifc.irqack = 1'b1;
      cyc();
      wr_reg(2'd3, 8'h03);
      ifc.src = 8'h00;
      idle(3);

      // level channel 0
      do_reset();
      wr_reg(2'd1, 8'h01);
      wr_reg(2'd3, 8'h01);
      ifc.src = 8'h01;
      idle(4);
      chk("level_irq", 32'(ifc.irq), 32'd1);
      ifc.irqack = 1'b1;
      cyc();
      rd_reg(2'd0, "level_after_ack", 8'h01);
      wr_reg(2'd0, 8'h01);
      rd_reg(2'd0, "level_after_wr", 8'h01);
      ifc.src = 8'h00;
      idle(2);
      rd_reg(2'd0, "level_fall_hold", 8'h01);
      rd_reg(2'd0, "level_fall_clear", 8'h00);
      wr_reg(2'd3, 8'h03);

      // masking
      do_reset();
      wr_reg(2'd3, 8'h01);
      ifc.src = 8'h08;
      idle(5);
      chk("masked_irq", 32'(ifc.irq), 32'd0);
      rd_reg(2'd0, "masked_pend", 8'h08);
      wr_reg(2'd1, 8'h08);
      cyc();
      chk("unmask_irq", 32'(ifc.irq), 32'd1);
      wr_reg(2'd1, 8'h00);
      cyc();
      chk("remask_irq", 32'(ifc.irq), 32'd0);
      ifc.src = 8'h00;

      // NMI path with gen = 0
      do_reset();
      ifc.nmi_src = 1'b1;
      idle(4);
      ifc.nmi_src = 1'b0;
      idle(2);
      chk("nmi_early", 32'(ifc.nmi), 32'd0);
      cyc();
      chk("nmi_set", 32'(ifc.nmi), 32'd1);
      ifc.nmiack = 1'b1;
      cyc();
      chk("nmi_ack", 32'(ifc.nmi), 32'd0);
      ifc.nmi_src = 1'b1;
      idle(3);
      ifc.nmi_src = 1'b0;
      idle(3);
      ifc.nmi_src = 1'b1;
      idle(3);
      ifc.nmi_src = 1'b0;
      idle(2);
      ifc.nmiack = 1'b1;
      cyc();
      chk("nmi_ack_vs_edge", 32'(ifc.nmi), 32'd1);
      ifc.nmiack = 1'b1;
      cyc();
      chk("nmi_ack2", 32'(ifc.nmi), 32'd0);

      // clear vs set on the same pend bit, EOI in idle
      do_reset();
      ifc.src = 8'h10;
      idle(2);
      wr_reg(2'd0, 8'h10);
      rd_reg(2'd0, "set_beats_clear", 8'h10);
      wr_reg(2'd3, 8'h02);
      rd_reg(2'd3, "eoi_in_idle", 8'h00);
      ifc.src = 8'h00;

      // randomized traffic
      do_reset();
      for (int n = 0; n < 2500; n++) begin
         if ($urandom_range(7) == 0) ifc.src[$urandom_range(7)] = ~ifc.src[$urandom_range(7)];
         if ($urandom_range(11) == 0) ifc.nmi_src = ~ifc.nmi_src;
         ifc.irqack = ifc.irq ? ($urandom_range(3) == 0) : ($urandom_range(15) == 0);
         ifc.nmiack = ifc.nmi ? ($urandom_range(3) == 0) : ($urandom_range(15) == 0);
         ifc.addr = 2'($urandom_range(3));
         ifc.rd   = $urandom_range(1) == 1;
         if ($urandom_range(5) == 0) begin
            ifc.wr    = 1'b1;
            ifc.wdata = 8'($urandom);
            if (ifc.addr == 2'd3 && $urandom_range(4) != 0) ifc.wdata[0] = 1'b1;
         end
         if ($urandom_range(599) == 0) begin
            ifc.wr = 1'b0; ifc.rd = 1'b0; ifc.irqack = 1'b0; ifc.nmiack = 1'b0;
            do_reset();
         end else begin
            cyc();
         end
      end
      for (int a = 0; a < 4; a++) begin
         ifc.rd = 1'b1; ifc.addr = 2'(a);
         cyc();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
